// File: rtl/yarp_instr_mem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder slice.
package yarp_instr_mem_resp_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMEM_WS_W = 4;

    localparam logic [XLEN-1:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_resp_state_t;

    // True when a byte address is misaligned or falls outside the array window.
    function automatic logic imem_addr_err(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input int unsigned     depth);
        logic [XLEN:0] limit;
        limit = {1'b0, base} + ((XLEN + 1)'(depth) << 2);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/yarp_instr_mem_resp_if.sv
// Fetch request/response bus plus the preload port of the instruction memory.
interface yarp_instr_mem_resp_if;
    import yarp_instr_mem_resp_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_valid;
    logic            err;
    logic            load_we;
    logic [XLEN-1:0] load_addr;
    logic [XLEN-1:0] load_data;

    modport master (
        output req, addr, load_we, load_addr, load_data,
        input  rd_data, rd_valid, err
    );

    modport slave (
        input  req, addr, load_we, load_addr, load_data,
        output rd_data, rd_valid, err
    );

endinterface

// File: rtl/yarp_instr_mem_resp_array.sv
// Synchronous 1R1W word array: registered read, read-before-write, no reset.
module yarp_imem_array
    import yarp_instr_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            re,
    input  logic [IDX_W-1:0] raddr,
    output logic [XLEN-1:0] rdata,
    input  logic            we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/yarp_instr_mem_resp.sv
// Instruction-fetch responder: captures a fetch address, waits WAIT_STATES cycles,
// then returns one word (or NOP plus err) with a single-cycle valid strobe.
module yarp_instr_mem_resp
    import yarp_instr_mem_resp_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter int unsigned     WAIT_STATES = 0,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  reset_n,
    yarp_instr_mem_resp_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IMEM_WS_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : IMEM_WS_W'(WAIT_STATES - 1);

    imem_resp_state_t     state_q;
    logic [IMEM_WS_W-1:0] cnt_q;
    logic [XLEN-1:0]      addr_q;
    logic                 rd_valid_q;
    logic                 err_q;
    logic                 hit_q;

    logic            capture;
    logic            enter_resp;
    logic [XLEN-1:0] rd_addr;
    logic            rd_err;
    logic            ld_err;
    logic            arr_re;
    logic            arr_we;
    logic [IDX_W-1:0] arr_raddr;
    logic [IDX_W-1:0] arr_waddr;
    logic [XLEN-1:0] arr_rdata;

    always_comb begin
        capture    = (state_q != WAIT) && bus.req;
        enter_resp = (capture && (WAIT_STATES == 0)) || ((state_q == WAIT) && (cnt_q == '0));
        // With no wait states the read happens on the capture edge, so bypass addr_q.
        rd_addr    = (state_q == WAIT) ? addr_q : bus.addr;
        rd_err     = imem_addr_err(rd_addr, BASE_ADDR, DEPTH_WORDS);
        ld_err     = imem_addr_err(bus.load_addr, BASE_ADDR, DEPTH_WORDS);
        arr_re     = enter_resp && !rd_err;
        arr_we     = bus.load_we && !ld_err;
        arr_raddr  = IDX_W'((rd_addr - BASE_ADDR) >> 2);
        arr_waddr  = IDX_W'((bus.load_addr - BASE_ADDR) >> 2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            rd_valid_q <= enter_resp;
            if (enter_resp) begin
                err_q <= rd_err;
                hit_q <= !rd_err;
            end
            case (state_q)
                IDLE, RESP: begin
                    if (bus.req) begin
                        addr_q <= bus.addr;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    yarp_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (bus.load_data)
    );

    // hit_q and err_q are exclusive; both clear after reset gives the zero reset value.
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;
    assign bus.rd_data  = hit_q ? arr_rdata : (err_q ? IMEM_NOP : '0);

endmodule
